// File: rtl/mips_defs.sv
// Shared definitions for the multiply/divide unit: op encodings,
// FSM states, counter type and default latencies.
package mips_defs;

    // Multiply/divide op encodings carried on md_unit.op
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Default busy latencies
    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // Latency counter; wide enough for any sensible latency setting
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit result generator: result = {HI, LO} for the
// requested multiply or divide, including divide-by-zero and the
// signed overflow case (most-negative / -1).
module md_core
    import mips_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_zero;
    logic        div_ovf;

    // Sign- or zero-extend to 64 bits so the low 64 product bits are exact
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // SV signed division truncates toward zero; remainder follows the dividend
    assign quot_s = $signed(a) / $signed(b);
    assign rem_s  = $signed(a) % $signed(b);
    assign quot_u = a / b;
    assign rem_u  = a % b;

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Select the result for the op; special divide cases override the operators
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    result = {32'd0, 32'h8000_0000};
                else
                    result = {rem_s, quot_s};
            end
            MD_DIVU: begin
                if (div_zero)
                    result = {a, 32'hFFFF_FFFF};
                else
                    result = {rem_u, quot_u};
            end
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit. Owns HI/LO, computes a result at
// the accepting edge into a pending register, and holds busy for a fixed
// latency before committing it.
module md_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] HILO_E
);

    md_state_t   state_reg, state_next;
    cnt_t        cnt_reg, cnt_next;
    logic [63:0] pend_reg, pend_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [63:0] core_result;

    md_core u_core (
        .op     (op),
        .a      (A),
        .b      (B),
        .result (core_result)
    );

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // Next-state logic: accept ops in IDLE, count down and commit in RUN
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            pend_next  = core_result;
                            cnt_next   = cnt_t'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_next  = core_result;
                            cnt_next   = cnt_t'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        MD_MTHI: hi_next = A;
                        MD_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any start while running is dropped; the hazard unit prevents it
                cnt_next = cnt_reg - cnt_t'(1);
                if (cnt_reg == cnt_t'(1)) begin
                    hi_next    = pend_reg[63:32];
                    lo_next    = pend_reg[31:0];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state_reg == RUN);
    assign HI     = hi_reg;
    assign LO     = lo_reg;
    assign HILO_E = rd_sel ? lo_reg : hi_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed vectors for each op,
// divide corner cases, ignored starts, and reset behaviour.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] HILO_E;

    int total = 0;
    int bad   = 0;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .rd_sel (rd_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .HILO_E (HILO_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // Issue one op, count busy cycles (bounded) and check the committed result
    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
        rd_sel = 1'b1; #1;
        chk({tag, "_hilo_e_lo"}, HILO_E, exp_lo);
        rd_sel = 1'b0; #1;
        chk({tag, "_hilo_e_hi"}, HILO_E, exp_hi);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0; rd_sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        // Arithmetic vectors (op, A, B, latency, HI, LO)
        run_md("mult",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 3'd3, 32'h0000_0007, 32'h0000_0000, 10, 32'h0000_0007, 32'hFFFF_FFFF);
        run_md("div0",  3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_md("divovf",3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_md("divneg",3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu",  3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF);
        run_md("multn", 3'd0, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000);

        // MTHI / MTLO: visible next cycle, no busy
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; rd_sel = 1'b0; #1;
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hilo_e", HILO_E, 32'h1234_5678);
        @(negedge clk);
        start = 1'b1; op = 3'd5; A = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; rd_sel = 1'b1; #1;
        chk("mtlo_lo", LO, 32'hCAFE_F00D);
        chk("mtlo_hilo_e", HILO_E, 32'hCAFE_F00D);
        chk("mtlo_hi_kept", HI, 32'h1234_5678);

        // Undefined op with start: ignored
        @(negedge clk);
        start = 1'b1; op = 3'd7; A = 32'hDEAD_BEEF; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("undef_busy", {31'd0, busy}, 32'd0);
        chk("undef_hi", HI, 32'h1234_5678);
        chk("undef_lo", LO, 32'hCAFE_F00D);

        // DIV 100/7 with a MULT start on busy cycle 2 that must be ignored
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("div_ign_busy_cycles", 32'(n), 32'd10);
        chk("div_ign_hi", HI, 32'd2);
        chk("div_ign_lo", LO, 32'd14);
        @(negedge clk);
        chk("div_ign_idle", {31'd0, busy}, 32'd0);

        // DIV aborted by reset on busy cycle 3
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_commit_hi", HI, 32'd0);
        chk("abort_no_commit_lo", LO, 32'd0);

        // Reset wins over a simultaneous MTHI
        start = 1'b1; op = 3'd4; A = 32'h5555_AAAA; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("rst_prio_hi", HI, 32'd0);
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
